// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed-length blinks separated by a
// mandatory low gap. Events arriving mid-blink are queued in a saturating counter.
module pulse_stretcher #(
  parameter int ON_CYCLES  = 500,
  parameter int OFF_CYCLES = 500,
  parameter int PEND_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  output logic              op,
  output logic              busy,
  output logic [PEND_W-1:0] pend,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  localparam logic [31:0]       ON_LAST  = 32'(ON_CYCLES - 1);
  localparam logic [31:0]       OFF_LAST = 32'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              op_q, op_d;
  logic              busy_q, busy_d;
  logic              gap_exit;
  logic              enq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      op_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    gap_exit = (state_q == GAP) && (cnt_q == OFF_LAST);
    // On the GAP exit edge a new event is either consumed directly or swapped
    // for the oldest queued one, so it never increments pend there.
    enq      = in && ((state_q == ON) || ((state_q == GAP) && !gap_exit));

    unique case (state_q)
      IDLE: begin
        if (in) begin
          state_d = ON;
          cnt_d   = '0;
        end
      end
      ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      GAP: begin
        if (gap_exit) begin
          cnt_d   = '0;
          state_d = ((pend_q != '0) || in) ? ON : IDLE;
          if (!in && (pend_q != '0)) pend_d = pend_q - 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (enq) begin
      if (pend_q == PEND_MAX) ovf_d = 1'b1;
      else                    pend_d = pend_q + 1'b1;
    end
  end

  always_comb begin
    op_d   = (state_d == ON);
    busy_d = (state_d != IDLE);
  end

  assign op   = op_q;
  assign busy = busy_q;
  assign pend = pend_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: table-driven main scenarios plus hand
// sequences for GAP-exit collision, async reset and 1-cycle phases.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_a, in_b;
  logic       op_a, busy_a, ovf_a;
  logic [1:0] pend_a;
  logic       op_b, busy_b, ovf_b;
  logic [1:0] pend_b;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  pulse_stretcher #(.ON_CYCLES(4), .OFF_CYCLES(3), .PEND_W(2)) dut_a (
    .clk(clk), .rst(rst), .in(in_a),
    .op(op_a), .busy(busy_a), .pend(pend_a), .ovf(ovf_a)
  );

  pulse_stretcher #(.ON_CYCLES(1), .OFF_CYCLES(1), .PEND_W(2)) dut_b (
    .clk(clk), .rst(rst), .in(in_b),
    .op(op_b), .busy(busy_b), .pend(pend_b), .ovf(ovf_b)
  );

  typedef struct {
    logic       in;
    logic       op;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic push(input int n, input logic i, input logic o, input logic b,
                      input logic [1:0] p, input logic v);
    vec_t t;
    t.in = i; t.op = o; t.busy = b; t.pend = p; t.ovf = v;
    for (int k = 0; k < n; k++) vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string name, input logic o, input logic b,
                       input logic [1:0] p, input logic v);
    chk({name, ".op"},   32'(op_a),   32'(o));
    chk({name, ".busy"}, 32'(busy_a), 32'(b));
    chk({name, ".pend"}, 32'(pend_a), 32'(p));
    chk({name, ".ovf"},  32'(ovf_a),  32'(v));
  endtask

  // Drive in, let one rising edge sample it, then settle past the edge.
  task automatic step(input logic i);
    in_a = i;
    @(posedge clk);
    #1;
  endtask

  int unsigned rises;
  logic        prev_op;
  int unsigned highs;

  initial begin
    rst  = 1'b1;
    in_a = 1'b0;
    in_b = 1'b0;
    #1;
    chk_a("reset", 1'b0, 1'b0, 2'd0, 1'b0);
    #2 rst = 1'b0;

    // Single event
    push(1, 1, 1, 1, 0, 0);
    push(3, 0, 1, 1, 0, 0);
    push(3, 0, 0, 1, 0, 0);
    push(2, 0, 0, 0, 0, 0);
    // Three consecutive events
    push(1, 1, 1, 1, 0, 0);
    push(1, 1, 1, 1, 1, 0);
    push(1, 1, 1, 1, 2, 0);
    push(1, 0, 1, 1, 2, 0);
    push(3, 0, 0, 1, 2, 0);
    push(4, 0, 1, 1, 1, 0);
    push(3, 0, 0, 1, 1, 0);
    push(4, 0, 1, 1, 0, 0);
    push(3, 0, 0, 1, 0, 0);
    push(2, 0, 0, 0, 0, 0);
    // Saturation
    push(1, 1, 1, 1, 0, 0);
    push(1, 1, 1, 1, 1, 0);
    push(1, 1, 1, 1, 2, 0);
    push(1, 1, 1, 1, 3, 0);
    push(2, 1, 0, 1, 3, 1);
    push(1, 0, 0, 1, 3, 1);
    push(4, 0, 1, 1, 2, 1);
    push(3, 0, 0, 1, 2, 1);
    push(4, 0, 1, 1, 1, 1);
    push(3, 0, 0, 1, 1, 1);
    push(4, 0, 1, 1, 0, 1);
    push(3, 0, 0, 1, 0, 1);
    push(2, 0, 0, 0, 0, 1);

    rises   = 0;
    prev_op = 1'b0;
    @(negedge clk);
    foreach (vecs[i]) begin
      step(vecs[i].in);
      chk_a($sformatf("vec%0d", i), vecs[i].op, vecs[i].busy, vecs[i].pend, vecs[i].ovf);
      if (op_a && !prev_op) rises++;
      prev_op = op_a;
    end
    chk("blink_count", rises, 32'd8);

    // Event collides with the GAP exit edge while pend is empty
    step(1);
    for (int k = 1; k <= 6; k++) step(0);
    chk_a("exit_pre", 1'b0, 1'b1, 2'd0, 1'b1);
    step(1);
    chk_a("exit_edge", 1'b1, 1'b1, 2'd0, 1'b1);
    for (int k = 8; k <= 10; k++) step(0);
    chk("exit_on_len", 32'(op_a), 32'd1);
    step(0);
    chk("exit_gap", 32'(op_a), 32'd0);
    for (int k = 12; k <= 14; k++) step(0);
    chk_a("exit_idle", 1'b0, 1'b0, 2'd0, 1'b1);

    // Async reset mid-ON with two events queued
    step(1);
    step(1);
    step(1);
    step(0);
    chk_a("pre_rst", 1'b1, 1'b1, 2'd2, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk_a("async_rst", 1'b0, 1'b0, 2'd0, 1'b0);
    #1 rst = 1'b0;
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      step(0);
      if (op_a || busy_a) highs++;
    end
    chk("post_rst_quiet", highs, 32'd0);
    step(1);
    chk_a("post_rst_event", 1'b1, 1'b1, 2'd0, 1'b0);

    // One-cycle ON and OFF phases
    in_b = 1'b1;
    @(posedge clk); #1;
    chk("deg_e0.op", 32'(op_b), 32'd1);
    @(posedge clk); #1;
    chk("deg_e1.op", 32'(op_b), 32'd0);
    chk("deg_e1.pend", 32'(pend_b), 32'd1);
    @(posedge clk); #1;
    in_b = 1'b0;
    chk("deg_e2.op", 32'(op_b), 32'd1);
    chk("deg_e2.pend", 32'(pend_b), 32'd1);
    @(posedge clk); #1;
    chk("deg_e3.op", 32'(op_b), 32'd0);
    @(posedge clk); #1;
    chk("deg_e4.op", 32'(op_b), 32'd1);
    chk("deg_e4.pend", 32'(pend_b), 32'd0);
    @(posedge clk); #1;
    chk("deg_e5.op", 32'(op_b), 32'd0);
    chk("deg_e5.busy", 32'(busy_b), 32'd1);
    @(posedge clk); #1;
    chk("deg_e6.busy", 32'(busy_b), 32'd0);
    chk("deg_e6.op", 32'(op_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
# pulse_stretcher

Output-side counterpart of the input debouncers: converts single-cycle event pulses (e.g. debounced button strobes or internal status events) into human-visible blinks on an LED or buzzer pin. Each accepted event produces exactly one fixed-length high phase followed by a mandatory low gap. Events that arrive while a blink is in progress are queued in a saturating counter, so none are merged or lost below the queue limit. The block sits between control logic and the board's output pins.

## Interface
- ON_CYCLES, 500, length of each high phase in clk cycles (≥1)
- OFF_CYCLES, 500, minimum low gap after each high phase in clk cycles (≥1)
- PEND_W, 4, width of the pending-event counter; queue depth is 2^PEND_W−1
- clk  input  1  system clock; all logic on posedge
- rst  input  1  reset, asynchronous, active-high
- in  input  1  event strobe; every cycle sampled high counts as one event
- op  output  1  stretched output, registered, drives the pin
- busy  output  1  high whenever state ≠ IDLE
- pend  output  PEND_W  number of queued events not yet started
- ovf  output  1  sticky: an event was dropped because pend was saturated

## Operation
- States: IDLE, ON, GAP. 32-bit phase counter cnt.
- IDLE: op=0. If in=1 → ON, cnt=0, op=1. The event is consumed directly; pend is unchanged.
- ON: op=1. If cnt==ON_CYCLES−1 → GAP, cnt=0, op=0. Otherwise cnt+1.
- GAP: op=0. If cnt==OFF_CYCLES−1, then:
  - if pend>0 or in=1 → ON, cnt=0, op=1, consuming one event;
  - otherwise → IDLE.
  - Otherwise cnt+1.
- Queueing: in=1 while in ON or GAP increments pend, except on a GAP exit edge.
- GAP exit edge with in=1:
  - if pend>0: pend is unchanged (the new event is queued and the oldest is consumed);
  - if pend=0: the in event is consumed directly and pend stays 0.
- GAP exit with in=0 and pend>0: pend−1.
- Saturation: an increment attempted at pend==2^PEND_W−1 leaves pend unchanged and sets ovf=1. ovf is cleared only by rst.
- Invariant: pend==0 whenever state==IDLE.
- ON_CYCLES=1 or OFF_CYCLES=1 is legal. The phase lasts exactly one cycle.

## Timing
- Reset values (applied immediately, no clock needed): state=IDLE, op=0, busy=0, cnt=0, pend=0, ovf=0.
- Latency: in sampled high at edge k (from IDLE) → op=1 after edge k.
- op stays high for exactly ON_CYCLES cycles and falls at edge k+ON_CYCLES.
- op stays low for at least OFF_CYCLES cycles.
- A queued blink's ON starts at edge k+ON_CYCLES+OFF_CYCLES.
- With no further events, busy falls at edge k+ON_CYCLES+OFF_CYCLES.
- Back-to-back queued events give a period of exactly ON_CYCLES+OFF_CYCLES, with no idle cycle between blinks.
- rst asserted mid-ON or mid-GAP: op drops at once and queued events are discarded.
- rst release: the first edge with rst=0 samples in normally.
- pend, busy and ovf are registered and update on the same edge as the state change.

## Test plan
Bench parameters: ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2.
- Single event: in=1 at edge 0 only → op=1 after edges 0–3, op=0 from edge 4, busy=0 from edge 7, pend=0 throughout.
- Three consecutive in=1 cycles at edges 0,1,2 → pend goes 0,1,2.
  - Blinks start at edges 0, 7 and 14, each lasting 4 cycles.
  - pend=1 after edge 7 and pend=0 after edge 14; busy=0 from edge 21.
- Saturation: event at edge 0, then in=1 at edges 1–5 → pend saturates at 3 after edge 3 and ovf=1 after edge 4.
  - Exactly 4 blinks occur in total; ovf stays 1 after going idle.
- Simultaneous exit: single event at edge 0, then in=1 at edge 7 (the GAP exit edge) with pend=0 → a new ON starts after edge 7 with no IDLE cycle, and pend stays 0.
- Async reset: during ON with pend=2, pulse rst between edges → op=0, busy=0, pend=0, ovf=0 immediately.
  - After release, no blink occurs until a new in.
- Degenerate parameters ON_CYCLES=1, OFF_CYCLES=1: in=1 for 3 consecutive cycles → op pattern is 1,0,1,0,1,0, and busy falls after the 6th cycle.
